// File: rtl/frv_mem_mon_pkg.sv
// Shared definitions for the memory bus protocol monitor: violation indices,
// the packed per-channel violation record and a counter-width helper.
package frv_mem_mon_pkg;

    localparam int STALL  = 0;
    localparam int WAIT   = 1;
    localparam int ORPHAN = 2;
    localparam int OVF    = 3;
    localparam int ERR    = 4;
    localparam int NVIOL  = 5;

    // Field order places each flag at the bit given by its index constant.
    typedef struct packed {
        logic err;
        logic ovf;
        logic orphan;
        logic rsp_wait;
        logic stall;
    } viol_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/frv_mem_chan_mon.sv
// Protocol monitor for a single req/gnt/recv/ack channel: tracks outstanding
// requests and raises sticky violation flags.
module frv_mem_chan_mon
    import frv_mem_mon_pkg::*;
#(
    parameter int MAX_OUT       = 4,
    parameter int GNT_STALL_MAX = 3,
    parameter int RSP_WAIT_MAX  = 4,
    parameter int OW            = cnt_width(MAX_OUT)
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             req,
    input  logic             gnt,
    input  logic             recv,
    input  logic             ack,
    input  logic             error,
    input  logic             clr,
    output logic [OW-1:0]    occ,
    output logic [NVIOL-1:0] viol
);

    localparam int SW = cnt_width(GNT_STALL_MAX);
    localparam int WW = cnt_width(RSP_WAIT_MAX);

    logic          accept;
    logic          resp;
    logic          valid_resp;
    logic          occ_empty;
    logic          occ_full;
    logic          stalling;
    logic          waiting;
    logic [SW-1:0] stall_cnt;
    logic [WW-1:0] wait_cnt;
    viol_t         set_v;
    viol_t         flags;

    assign accept     = req & gnt;
    assign resp       = recv & ack;
    assign occ_empty  = (occ == '0);
    assign occ_full   = (occ == OW'(MAX_OUT));
    assign valid_resp = resp & ~occ_empty;
    assign stalling   = req & ~gnt;
    assign waiting    = ~occ_empty & ~resp;

    // A flag fires on the cycle that completes the threshold run, and keeps
    // firing while the run continues so a clear mid-run is overridden.
    always_comb begin
        // NOTE: default every combinational output first so no latch is inferred.
        set_v          = '0;
        set_v.stall    = stalling && (stall_cnt >= SW'(GNT_STALL_MAX - 1));
        set_v.rsp_wait = waiting && (wait_cnt >= WW'(RSP_WAIT_MAX - 1));
        set_v.orphan   = resp && occ_empty;
        set_v.ovf      = accept && occ_full && !resp;
        set_v.err      = resp && error;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            occ       <= '0;
            stall_cnt <= '0;
            wait_cnt  <= '0;
            flags     <= '0;
        end else begin
            if (accept && !valid_resp && !occ_full)
                occ <= occ + 1'b1;
            else if (valid_resp && !accept)
                occ <= occ - 1'b1;

            if (!stalling)
                stall_cnt <= '0;
            else if (stall_cnt != SW'(GNT_STALL_MAX))
                stall_cnt <= stall_cnt + 1'b1;

            if (!waiting)
                wait_cnt <= '0;
            else if (wait_cnt != WW'(RSP_WAIT_MAX))
                wait_cnt <= wait_cnt + 1'b1;

            // New events win over a clear in the same cycle.
            flags <= set_v | (flags & {NVIOL{~clr}});
        end
    end

    assign viol = flags;

endmodule

// File: rtl/frv_mem_bus_monitor.sv
// Multi-channel memory bus monitor: one independent channel checker per
// channel plus a global OR of all sticky violation flags.
module frv_mem_bus_monitor
    import frv_mem_mon_pkg::*;
#(
    parameter int  NCH           = 2,
    parameter int  MAX_OUT       = 4,
    parameter int  GNT_STALL_MAX = 3,
    parameter int  RSP_WAIT_MAX  = 4,
    localparam int OW            = cnt_width(MAX_OUT)
) (
    input  logic              g_clk,
    input  logic              g_resetn,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    gnt,
    input  logic [NCH-1:0]    recv,
    input  logic [NCH-1:0]    ack,
    input  logic [NCH-1:0]    error,
    input  logic [NCH-1:0]    clr,
    output logic [NCH*OW-1:0] occ,
    output logic [NCH-1:0]    viol_stall,
    output logic [NCH-1:0]    viol_wait,
    output logic [NCH-1:0]    viol_orphan,
    output logic [NCH-1:0]    viol_ovf,
    output logic [NCH-1:0]    viol_err,
    output logic              any_viol
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic [NVIOL-1:0] viol;

        frv_mem_chan_mon #(
            .MAX_OUT       (MAX_OUT),
            .GNT_STALL_MAX (GNT_STALL_MAX),
            .RSP_WAIT_MAX  (RSP_WAIT_MAX),
            .OW            (OW)
        ) u_chan (
            .g_clk    (g_clk),
            .g_resetn (g_resetn),
            .req      (req[i]),
            .gnt      (gnt[i]),
            .recv     (recv[i]),
            .ack      (ack[i]),
            .error    (error[i]),
            .clr      (clr[i]),
            .occ      (occ[i*OW +: OW]),
            .viol     (viol)
        );

        assign viol_stall[i]  = viol[STALL];
        assign viol_wait[i]   = viol[WAIT];
        assign viol_orphan[i] = viol[ORPHAN];
        assign viol_ovf[i]    = viol[OVF];
        assign viol_err[i]    = viol[ERR];
    end

    assign any_viol = |{viol_stall, viol_wait, viol_orphan, viol_ovf, viol_err};

endmodule

// File: tb/tb_frv_mem_bus_monitor.sv
// Bench for frv_mem_bus_monitor: directed vector table, a reset sequence and
// randomized traffic checked against a run-length reference model.
module tb_frv_mem_bus_monitor;

    localparam int NCH           = 2;
    localparam int MAX_OUT       = 4;
    localparam int GNT_STALL_MAX = 3;
    localparam int RSP_WAIT_MAX  = 4;
    localparam int OW            = 3;

    logic              g_clk = 1'b0;
    logic              g_resetn;
    logic [NCH-1:0]    req, gnt, recv, ack, error, clr;
    logic [NCH*OW-1:0] occ;
    logic [NCH-1:0]    viol_stall, viol_wait, viol_orphan, viol_ovf, viol_err;
    logic              any_viol;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 g_clk = ~g_clk;

    frv_mem_bus_monitor #(
        .NCH           (NCH),
        .MAX_OUT       (MAX_OUT),
        .GNT_STALL_MAX (GNT_STALL_MAX),
        .RSP_WAIT_MAX  (RSP_WAIT_MAX)
    ) dut (
        .g_clk       (g_clk),
        .g_resetn    (g_resetn),
        .req         (req),
        .gnt         (gnt),
        .recv        (recv),
        .ack         (ack),
        .error       (error),
        .clr         (clr),
        .occ         (occ),
        .viol_stall  (viol_stall),
        .viol_wait   (viol_wait),
        .viol_orphan (viol_orphan),
        .viol_ovf    (viol_ovf),
        .viol_err    (viol_err),
        .any_viol    (any_viol)
    );

    typedef struct {
        bit       rstn;
        bit [1:0] req, gnt, recv, ack, err, clr;
        int       occ0, occ1;
        bit [1:0] stall, wt, orph, ovf, verr;
    } vec_t;

    vec_t vecs[$];

    // Reference model: unbounded run lengths and integer occupancy.
    int       m_occ[NCH];
    int       m_srun[NCH];
    int       m_wrun[NCH];
    bit [1:0] m_stall, m_wait, m_orph, m_ovf, m_err;

    function automatic vec_t mk(input bit rstn, input bit [1:0] rq, gn, rv, ak, er, cl,
                                input int o0, o1, input bit [1:0] st, wt, orp, ov, ve);
        vec_t v;
        v.rstn = rstn; v.req = rq; v.gnt = gn; v.recv = rv; v.ack = ak; v.err = er; v.clr = cl;
        v.occ0 = o0; v.occ1 = o1; v.stall = st; v.wt = wt; v.orph = orp; v.ovf = ov; v.verr = ve;
        return v;
    endfunction

    function automatic logic [16:0] obs();
        return {occ, viol_stall, viol_wait, viol_orphan, viol_ovf, viol_err, any_viol};
    endfunction

    function automatic logic [16:0] vec_exp(input vec_t v);
        logic [9:0] f;
        f = {v.stall, v.wt, v.orph, v.ovf, v.verr};
        return {3'(v.occ1), 3'(v.occ0), f, |f};
    endfunction

    function automatic logic [16:0] model_obs();
        logic [5:0] o;
        logic [9:0] f;
        for (int c = 0; c < NCH; c++) o[c*OW +: OW] = OW'(m_occ[c]);
        f = {m_stall, m_wait, m_orph, m_ovf, m_err};
        return {o, f, |f};
    endfunction

    task automatic model_edge();
        bit acc, rsp;
        for (int c = 0; c < NCH; c++) begin
            if (!g_resetn) begin
                m_occ[c] = 0; m_srun[c] = 0; m_wrun[c] = 0;
                m_stall[c] = 0; m_wait[c] = 0; m_orph[c] = 0; m_ovf[c] = 0; m_err[c] = 0;
            end else begin
                acc = req[c] && gnt[c];
                rsp = recv[c] && ack[c];
                m_srun[c] = (req[c] && !gnt[c]) ? m_srun[c] + 1 : 0;
                m_wrun[c] = (m_occ[c] > 0 && !rsp) ? m_wrun[c] + 1 : 0;
                m_stall[c] = (m_srun[c] >= GNT_STALL_MAX) || (m_stall[c] && !clr[c]);
                m_wait[c]  = (m_wrun[c] >= RSP_WAIT_MAX) || (m_wait[c] && !clr[c]);
                m_orph[c]  = (rsp && m_occ[c] == 0) || (m_orph[c] && !clr[c]);
                m_ovf[c]   = (acc && m_occ[c] == MAX_OUT && !rsp) || (m_ovf[c] && !clr[c]);
                m_err[c]   = (rsp && error[c]) || (m_err[c] && !clr[c]);
                m_occ[c]   = m_occ[c] + int'(acc) - int'(rsp && m_occ[c] > 0);
                if (m_occ[c] > MAX_OUT) m_occ[c] = MAX_OUT;
            end
        end
    endtask

    task automatic drive(input vec_t v);
        g_resetn = v.rstn;
        req = v.req; gnt = v.gnt; recv = v.recv; ack = v.ack; error = v.err; clr = v.clr;
    endtask

    task automatic tick();
        model_edge();
        @(posedge g_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p_req, p_gnt, p_rsp;

        // rstn, req, gnt, recv, ack, err, clr | occ0, occ1, stall, wait, orphan, ovf, err
        vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        // ch0 stall: three ungranted cycles, then clear
        vecs.push_back(mk(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        // ch0 grant arrives on the third cycle: no flag
        vecs.push_back(mk(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        // ch1 overflow: four accepts, fifth overflows (wait also trips)
        vecs.push_back(mk(1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 4, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00));
        // accept + resp at full: no flag, occupancy unchanged
        vecs.push_back(mk(1, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 0, 4, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 0, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 0, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        // ch0 orphan, then orphan + accept together with clr
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 1, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00));
        // ch0 response wait: four idle cycles with one outstanding
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        // response lands on the fourth cycle: no flag
        vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        // ch1 error response, clear, then clear coincident with a new error
        vecs.push_back(mk(1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10));
        // error without a response is ignored
        vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10));

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k]);
            tick();
            check($sformatf("vec%0d", k), 32'(obs()), 32'(vec_exp(vecs[k])));
        end

        // Reset with three outstanding on ch0 discards them; a later response is an orphan.
        drive(mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 0, 0));
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(mk(1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
            tick();
        end
        check("occ0 before reset", 32'(occ), 32'd3);
        drive(mk(0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        tick();
        check("all zero after reset", 32'(obs()), 32'd0);
        drive(mk(1, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        tick();
        check("orphan after reset", 32'({occ, viol_orphan, any_viol}), 32'({6'd0, 2'b01, 1'b1}));

        // Randomized traffic against the reference model, bias changing per phase.
        drive(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
        tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            p_req = 30 + 20 * ((cyc / 500) % 3);
            p_gnt = 80 - 25 * ((cyc / 750) % 3);
            p_rsp = 15 + 15 * ((cyc / 600) % 3);
            g_resetn = ($urandom_range(0, 399) != 0);
            for (int c = 0; c < NCH; c++) begin
                req[c]   = ($urandom_range(0, 99) < p_req);
                gnt[c]   = ($urandom_range(0, 99) < p_gnt);
                recv[c]  = ($urandom_range(0, 99) < p_rsp + 20);
                ack[c]   = ($urandom_range(0, 99) < 70);
                error[c] = ($urandom_range(0, 19) == 0);
                clr[c]   = ($urandom_range(0, 24) == 0);
            end
            tick();
            check($sformatf("rand cyc%0d", cyc), 32'(obs()), 32'(model_obs()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
